// File: rtl/boot_sequencer_if.sv
// Request/response bundle between the boot sequencer and its controller.
// The controller drives the request side; the sequencer drives the registered status/fire side.
interface boot_sequencer_if #(
    parameter int IMAGE_W = 2
);
    logic               boot_req;
    logic [IMAGE_W-1:0] boot_image;
    logic               boot_cancel;
    logic               boot_ack;
    logic               busy;
    logic               programn;
    logic               warmboot_boot;
    logic [IMAGE_W-1:0] warmboot_sel;

    modport master (
        output boot_req, boot_image, boot_cancel,
        input  boot_ack, busy, programn, warmboot_boot, warmboot_sel
    );

    modport slave (
        input  boot_req, boot_image, boot_cancel,
        output boot_ack, busy, programn, warmboot_boot, warmboot_sel
    );
endinterface

// File: rtl/boot_sequencer.sv
// Delayed reconfiguration trigger: accept a boot request, wait DELAY_CYCLES, then
// drive PROGRAMN low / warm-boot strobe for PULSE_CYCLES, optionally latching PROGRAMN low.
module boot_sequencer #(
    parameter int DELAY_CYCLES = 256,
    parameter int PULSE_CYCLES = 16,
    parameter int HOLD_MODE    = 1,
    parameter int IMAGE_W      = 2
) (
    input  logic             clk_usb,
    input  logic             reset,
    boot_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ARMED, FIRE, HOLD} state_t;

    localparam logic [15:0] DLY_LD = 16'(DELAY_CYCLES - 1);
    localparam logic [15:0] PLS_LD = 16'(PULSE_CYCLES - 1);

    state_t             state, state_nx;
    logic [15:0]        cnt, cnt_nx;
    logic               ack_nx;
    logic [IMAGE_W-1:0] sel_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ack_nx   = 1'b0;
        sel_nx   = bus.warmboot_sel;
        case (state)
            IDLE: begin
                // cancel beats a simultaneous request
                if (bus.boot_req && !bus.boot_cancel) begin
                    state_nx = ARMED;
                    cnt_nx   = DLY_LD;
                    sel_nx   = bus.boot_image;
                    ack_nx   = 1'b1;
                end
            end
            ARMED: begin
                if (bus.boot_cancel) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    state_nx = FIRE;
                    cnt_nx   = PLS_LD;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            FIRE: begin
                if (cnt == '0) begin
                    state_nx = (HOLD_MODE != 0) ? HOLD : IDLE;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end
            HOLD:    state_nx = HOLD;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_usb) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            bus.boot_ack      <= 1'b0;
            bus.busy          <= 1'b0;
            bus.programn      <= 1'b1;
            bus.warmboot_boot <= 1'b0;
            bus.warmboot_sel  <= '0;
        end else begin
            state             <= state_nx;
            cnt               <= cnt_nx;
            bus.boot_ack      <= ack_nx;
            bus.busy          <= (state_nx != IDLE);
            bus.programn      <= !((state_nx == FIRE) || (state_nx == HOLD));
            bus.warmboot_boot <= (state_nx == FIRE);
            bus.warmboot_sel  <= sel_nx;
        end
    end
endmodule
